// File: rtl/router_pkg.sv
// Shared defaults and index helpers for the VC router allocation core.
package router_pkg;

   localparam int DEF_NUM_PORTS = 5;
   localparam int DEF_NUM_VC    = 4;

   // Flat VC index: port-major, VC-minor.
   function automatic int flat_idx(input int port, input int vc, input int num_vc);
      return port * num_vc + vc;
   endfunction

endpackage

// File: rtl/router_top_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching from the pointer; the pointer
// moves to one past the winner only when a grant is issued and update is set.
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] req,
   input  logic         update,
   output logic [N-1:0] gnt
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] r_ptr;
   logic [PW-1:0] w_win;
   logic          w_found;

   // Pick the first requester at or after the pointer, wrapping around.
   always_comb begin
      gnt     = '0;
      w_win   = '0;
      w_found = 1'b0;
      for (int k = 0; k < N; k++) begin
         int idx;
         idx = (int'(r_ptr) + k) % N;
         if (!w_found && req[idx]) begin
            gnt[idx] = 1'b1;
            w_win    = PW'(idx);
            w_found  = 1'b1;
         end
      end
   end

   // Advance the pointer past the winner, wrapping from the last index to 0.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ptr <= '0;
      end else if (update && w_found) begin
         r_ptr <= (w_win == PW'(N - 1)) ? '0 : w_win + 1'b1;
      end
   end

endmodule

// File: rtl/router_top.sv
// VC router allocation core: separable input-first VC allocation feeding
// registered bindings, then two-stage round-robin switch allocation.
module router_top
   import router_pkg::*;
#(
   parameter int NUM_PORTS = DEF_NUM_PORTS,
   parameter int NUM_VC    = DEF_NUM_VC,
   parameter int PORT_BITS = $clog2(NUM_PORTS),
   parameter int VC_BITS   = $clog2(NUM_VC)
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_PORTS-1:0]        dst_port [NUM_VC*NUM_PORTS],
   input  logic [NUM_VC*NUM_PORTS-1:0] vc_availability,
   output logic [VC_BITS-1:0]          vc_index [NUM_PORTS],
   output logic [NUM_PORTS-1:0]        vc_read_valid
);

   localparam int NI = NUM_VC * NUM_PORTS;

   // Registered state: output VC held by each input VC, and last dst seen.
   logic [NI-1:0]        r_alloc    [NI];
   logic [NUM_PORTS-1:0] r_prev_dst [NI];

   // VC allocation signals.
   logic [NUM_PORTS-1:0] w_dst        [NI];
   logic [NI-1:0]        w_held;
   logic [NI-1:0]        w_free;
   logic [NUM_VC-1:0]    w_va_in_req  [NI];
   logic [NUM_VC-1:0]    w_va_in_gnt  [NI];
   logic [NI-1:0]        w_va_in_upd;
   logic [NI-1:0]        w_va_out_req [NI];
   logic [NI-1:0]        w_va_out_gnt [NI];
   logic [NI-1:0]        w_vc_grants  [NI];

   // Switch allocation signals.
   logic [NI-1:0]        w_elig;
   logic [NUM_VC-1:0]    w_sa_in_req   [NUM_PORTS];
   logic [NUM_VC-1:0]    w_sa_in_gnt   [NUM_PORTS];
   logic [VC_BITS-1:0]   w_sel_vc      [NUM_PORTS];
   logic [PORT_BITS-1:0] w_tgt         [NUM_PORTS];
   logic [NUM_PORTS-1:0] w_has;
   logic [NUM_PORTS-1:0] w_sa_out_req  [NUM_PORTS];
   logic [NUM_PORTS-1:0] w_alloc_ports [NUM_PORTS];
   logic [NUM_PORTS-1:0] w_sa_win;

   // Free output VCs and per-input-VC candidate sets (lowest dst bit wins).
   always_comb begin
      w_held = '0;
      for (int i = 0; i < NI; i++) begin
         w_dst[i]       = dst_port[i] & (~dst_port[i] + 1'b1);
         w_va_in_req[i] = '0;
         w_held         = w_held | r_alloc[i];
      end
      w_free = vc_availability & ~w_held;
      for (int i = 0; i < NI; i++) begin
         if (r_alloc[i] == '0) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
               if (w_dst[i][p]) w_va_in_req[i] = w_free[p*NUM_VC +: NUM_VC];
            end
         end
      end
   end

   // Route each input VC's chosen candidate to that output VC's arbiter.
   always_comb begin
      for (int j = 0; j < NI; j++) w_va_out_req[j] = '0;
      for (int i = 0; i < NI; i++) begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            for (int v = 0; v < NUM_VC; v++) begin
               if (w_dst[i][p] && w_va_in_gnt[i][v]) w_va_out_req[flat_idx(p, v, NUM_VC)][i] = 1'b1;
            end
         end
      end
   end

   // Transpose output-side grants back to per-input-VC grant vectors.
   always_comb begin
      w_va_in_upd = '0;
      for (int i = 0; i < NI; i++) begin
         w_vc_grants[i] = '0;
         for (int j = 0; j < NI; j++) w_vc_grants[i][j] = w_va_out_gnt[j][i];
         w_va_in_upd[i] = |w_vc_grants[i];
      end
   end

   // Bind new grants; drop a binding once its dst goes idle or changes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NI; i++) begin
            r_alloc[i]    <= '0;
            r_prev_dst[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NI; i++) begin
            r_prev_dst[i] <= dst_port[i];
            if (r_alloc[i] != '0) begin
               if (dst_port[i] == '0 || dst_port[i] != r_prev_dst[i]) r_alloc[i] <= '0;
            end else begin
               r_alloc[i] <= w_vc_grants[i];
            end
         end
      end
   end

   // An input VC may bid for the switch while bound to an output VC with credit.
   always_comb begin
      w_elig = '0;
      for (int i = 0; i < NI; i++) w_elig[i] = (r_alloc[i] & vc_availability) != '0;
      for (int p = 0; p < NUM_PORTS; p++) w_sa_in_req[p] = w_elig[p*NUM_VC +: NUM_VC];
   end

   // Encode each input port's chosen VC and the output port it targets.
   always_comb begin
      for (int p = 0; p < NUM_PORTS; p++) begin
         w_sel_vc[p] = '0;
         w_tgt[p]    = '0;
         w_has[p]    = |w_sa_in_gnt[p];
         for (int v = 0; v < NUM_VC; v++) begin
            if (w_sa_in_gnt[p][v]) begin
               w_sel_vc[p] = VC_BITS'(v);
               for (int o = 0; o < NUM_PORTS; o++) begin
                  if (r_alloc[flat_idx(p, v, NUM_VC)][o*NUM_VC +: NUM_VC] != '0) w_tgt[p] = PORT_BITS'(o);
               end
            end
         end
      end
      for (int o = 0; o < NUM_PORTS; o++) begin
         w_sa_out_req[o] = '0;
         for (int p = 0; p < NUM_PORTS; p++) w_sa_out_req[o][p] = w_has[p] && (w_tgt[p] == PORT_BITS'(o));
      end
   end

   // An input port wins when some output port granted it.
   always_comb begin
      w_sa_win = '0;
      for (int o = 0; o < NUM_PORTS; o++) w_sa_win = w_sa_win | w_alloc_ports[o];
   end

   genvar gi;
   generate
      for (gi = 0; gi < NI; gi++) begin : g_va
         rr_arbiter #(.N(NUM_VC)) u_in_arb (
            .clk(clk), .reset(reset), .req(w_va_in_req[gi]),
            .update(w_va_in_upd[gi]), .gnt(w_va_in_gnt[gi]));
         rr_arbiter #(.N(NI)) u_out_arb (
            .clk(clk), .reset(reset), .req(w_va_out_req[gi]),
            .update(1'b1), .gnt(w_va_out_gnt[gi]));
      end
      for (gi = 0; gi < NUM_PORTS; gi++) begin : g_sa
         rr_arbiter #(.N(NUM_VC)) u_in_arb (
            .clk(clk), .reset(reset), .req(w_sa_in_req[gi]),
            .update(w_sa_win[gi]), .gnt(w_sa_in_gnt[gi]));
         rr_arbiter #(.N(NUM_PORTS)) u_out_arb (
            .clk(clk), .reset(reset), .req(w_sa_out_req[gi]),
            .update(1'b1), .gnt(w_alloc_ports[gi]));
      end
   endgenerate

   // Register switch results; a losing port keeps its last vc_index.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vc_read_valid <= '0;
         for (int p = 0; p < NUM_PORTS; p++) vc_index[p] <= '0;
      end else begin
         vc_read_valid <= w_sa_win;
         for (int p = 0; p < NUM_PORTS; p++) begin
            if (w_sa_win[p]) vc_index[p] <= w_sel_vc[p];
         end
      end
   end

endmodule

// File: tb/tb_router_top.sv
// Bench for router_top: directed scenarios with hand-derived expectations and
// a randomized run against an integer-level model of the allocation rules.
module tb_router_top;
   import router_pkg::*;

   localparam int NP = DEF_NUM_PORTS;
   localparam int NV = DEF_NUM_VC;
   localparam int NI = NP * NV;
   localparam int VB = $clog2(NV);

   logic          clk = 1'b0;
   logic          reset;
   logic [NP-1:0] dst_port [NI];
   logic [NI-1:0] vc_availability;
   logic [VB-1:0] vc_index [NP];
   logic [NP-1:0] vc_read_valid;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   router_top dut (
      .clk(clk), .reset(reset), .dst_port(dst_port),
      .vc_availability(vc_availability), .vc_index(vc_index),
      .vc_read_valid(vc_read_valid));

   // Reference model: bindings as output-VC numbers (-1 = none), plain int pointers.
   int            m_bind [NI];
   int            m_prev [NI];
   int            m_vin_ptr [NI];
   int            m_vout_ptr [NI];
   int            m_sin_ptr [NP];
   int            m_sout_ptr [NP];
   logic [NP-1:0] m_valid;
   int            m_idx [NP];

   task automatic model_reset();
      for (int i = 0; i < NI; i++) begin
         m_bind[i] = -1; m_prev[i] = 0; m_vin_ptr[i] = 0; m_vout_ptr[i] = 0;
      end
      for (int p = 0; p < NP; p++) begin
         m_sin_ptr[p] = 0; m_sout_ptr[p] = 0; m_idx[p] = 0;
      end
      m_valid = '0;
   endtask

   task automatic model_clock();
      int  choice [NI];
      int  won [NI];
      bit  held [NI];
      int  sel [NP];
      int  tgt [NP];
      int  d, port, v, f, i, p, winner;
      for (int j = 0; j < NI; j++) held[j] = 0;
      for (int k = 0; k < NI; k++) if (m_bind[k] >= 0) held[m_bind[k]] = 1;
      // VC allocation: each unbound requester picks a free VC on its port.
      for (int k = 0; k < NI; k++) begin
         choice[k] = -1; won[k] = -1;
         d = int'(dst_port[k]);
         if (m_bind[k] < 0 && d != 0) begin
            port = -1;
            for (int b = 0; b < NP; b++) if (port < 0 && d[b]) port = b;
            for (int s = 0; s < NV; s++) begin
               v = (m_vin_ptr[k] + s) % NV;
               f = port * NV + v;
               if (choice[k] < 0 && vc_availability[f] && !held[f]) choice[k] = f;
            end
         end
      end
      for (int j = 0; j < NI; j++) begin
         winner = -1;
         for (int s = 0; s < NI; s++) begin
            i = (m_vout_ptr[j] + s) % NI;
            if (winner < 0 && choice[i] == j) winner = i;
         end
         if (winner >= 0) begin
            won[winner] = j;
            m_vout_ptr[j] = (winner + 1) % NI;
            m_vin_ptr[winner] = (j % NV + 1) % NV;
         end
      end
      // Switch allocation on the bindings as they stood before this edge.
      for (int q = 0; q < NP; q++) begin
         sel[q] = -1; tgt[q] = -1;
         for (int s = 0; s < NV; s++) begin
            v = (m_sin_ptr[q] + s) % NV;
            i = q * NV + v;
            if (sel[q] < 0 && m_bind[i] >= 0 && vc_availability[m_bind[i]]) sel[q] = v;
         end
         if (sel[q] >= 0) tgt[q] = m_bind[q * NV + sel[q]] / NV;
      end
      m_valid = '0;
      for (int o = 0; o < NP; o++) begin
         winner = -1;
         for (int s = 0; s < NP; s++) begin
            p = (m_sout_ptr[o] + s) % NP;
            if (winner < 0 && tgt[p] == o) winner = p;
         end
         if (winner >= 0) begin
            m_valid[winner] = 1'b1;
            m_idx[winner] = sel[winner];
            m_sout_ptr[o] = (winner + 1) % NP;
            m_sin_ptr[winner] = (sel[winner] + 1) % NV;
         end
      end
      // Binding hold/release, then new grants for unbound VCs.
      for (int k = 0; k < NI; k++) begin
         d = int'(dst_port[k]);
         if (m_bind[k] >= 0) begin
            if (d == 0 || d != m_prev[k]) m_bind[k] = -1;
         end else begin
            m_bind[k] = won[k];
         end
         m_prev[k] = d;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (reset) model_clock(); else model_reset();
      #1;
   endtask

   task automatic apply_reset();
      reset = 1'b0;
      for (int i = 0; i < NI; i++) dst_port[i] = '0;
      vc_availability = '1;
      tick();
      tick();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      vc_availability = '1;
      dst_port[0] = 5'b00001;
      dst_port[5] = 5'b00100;
      tick(); tick(); tick();
      n_cmp++;
      if (vc_read_valid !== 5'b00000) begin
         n_err++;
         $display("FAIL reset_valid: got %b want 00000", vc_read_valid);
      end
      for (int p = 0; p < NP; p++) begin
         n_cmp++;
         if (vc_index[p] !== '0) begin
            n_err++;
            $display("FAIL reset_index[%0d]: got %0d want 0", p, vc_index[p]);
         end
      end
   endtask

   task automatic test_scenario1();
      apply_reset();
      dst_port[0] = 5'b00001;
      dst_port[1] = 5'b01000;
      tick();
      n_cmp++;
      if (vc_read_valid !== 5'b00000) begin
         n_err++;
         $display("FAIL s1_bind_edge: got %b want 00000", vc_read_valid);
      end
      for (int e = 2; e <= 5; e++) begin
         tick();
         n_cmp++;
         if (vc_read_valid !== 5'b00001) begin
            n_err++;
            $display("FAIL s1_valid edge%0d: got %b want 00001", e, vc_read_valid);
         end
         n_cmp++;
         if (vc_index[0] !== VB'((e - 2) % 2)) begin
            n_err++;
            $display("FAIL s1_alternate edge%0d: got %0d want %0d", e, vc_index[0], (e - 2) % 2);
         end
      end
   endtask

   task automatic test_availability();
      logic [VB-1:0] exp_after [2];
      vc_availability[0] = 1'b0;
      for (int c = 0; c < 4; c++) begin
         tick();
         n_cmp++;
         if (vc_read_valid !== 5'b00001 || vc_index[0] !== VB'(1)) begin
            n_err++;
            $display("FAIL avail_block cyc%0d: got valid=%b idx=%0d want valid=00001 idx=1", c, vc_read_valid, vc_index[0]);
         end
      end
      vc_availability[0] = 1'b1;
      exp_after = '{VB'(0), VB'(1)};
      for (int c = 0; c < 2; c++) begin
         tick();
         n_cmp++;
         if (vc_index[0] !== exp_after[c]) begin
            n_err++;
            $display("FAIL avail_restore cyc%0d: got %0d want %0d", c, vc_index[0], exp_after[c]);
         end
      end
   endtask

   task automatic test_conflict();
      logic [NP-1:0] exp_v [6];
      exp_v = '{5'b00000, 5'b00001, 5'b00010, 5'b00001, 5'b00010, 5'b00001};
      apply_reset();
      dst_port[0] = 5'b00010;
      dst_port[4] = 5'b00010;
      for (int e = 0; e < 6; e++) begin
         tick();
         n_cmp++;
         if (vc_read_valid !== exp_v[e]) begin
            n_err++;
            $display("FAIL conflict_valid edge%0d: got %b want %b", e + 1, vc_read_valid, exp_v[e]);
         end
         if (exp_v[e] != '0) begin
            n_cmp++;
            if (vc_index[exp_v[e][1] ? 1 : 0] !== '0) begin
               n_err++;
               $display("FAIL conflict_index edge%0d: got %0d want 0", e + 1, vc_index[exp_v[e][1] ? 1 : 0]);
            end
         end
      end
   endtask

   task automatic test_release();
      logic [NP-1:0] exp_v [6];
      exp_v = '{5'b00000, 5'b00001, 5'b00001, 5'b00001, 5'b00000, 5'b00010};
      apply_reset();
      vc_availability = 20'h00001;
      dst_port[0] = 5'b00001;
      for (int e = 0; e < 6; e++) begin
         tick();
         if (e == 0) dst_port[4] = 5'b00001;
         if (e == 2) dst_port[0] = 5'b00000;
         n_cmp++;
         if (vc_read_valid !== exp_v[e]) begin
            n_err++;
            $display("FAIL release_valid edge%0d: got %b want %b", e + 1, vc_read_valid, exp_v[e]);
         end
      end
      n_cmp++;
      if (vc_index[1] !== '0) begin
         n_err++;
         $display("FAIL release_reuse_index: got %0d want 0", vc_index[1]);
      end
   endtask

   task automatic test_exhaustion();
      bit seen;
      apply_reset();
      for (int p = 0; p < NP; p++) dst_port[p * NV] = 5'b00100;
      for (int c = 0; c < 12; c++) begin
         tick();
         n_cmp++;
         if (vc_read_valid[4] !== 1'b0) begin
            n_err++;
            $display("FAIL exhaust_fifth_idle cyc%0d: got %b want 0", c, vc_read_valid[4]);
         end
      end
      dst_port[0] = 5'b00000;
      for (int c = 0; c < 2; c++) begin
         tick();
         n_cmp++;
         if (vc_read_valid[4] !== 1'b0) begin
            n_err++;
            $display("FAIL exhaust_too_early cyc%0d: got %b want 0", c, vc_read_valid[4]);
         end
      end
      seen = 0;
      for (int c = 0; c < 10 && !seen; c++) begin
         tick();
         if (vc_read_valid[4] === 1'b1) seen = 1;
      end
      n_cmp++;
      if (!seen) begin
         n_err++;
         $display("FAIL exhaust_fifth_served: got no read within 10 cycles want a read");
      end else begin
         n_cmp++;
         if (vc_index[4] !== '0) begin
            n_err++;
            $display("FAIL exhaust_fifth_index: got %0d want 0", vc_index[4]);
         end
      end
   endtask

   task automatic test_random();
      int r;
      apply_reset();
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < NI; i++) begin
            if ($urandom_range(0, 9) == 0) begin
               r = $urandom_range(0, 9);
               if (r <= 2) dst_port[i] = '0;
               else if (r <= 8) dst_port[i] = NP'(1) << $urandom_range(0, NP - 1);
               else dst_port[i] = NP'($urandom_range(1, (1 << NP) - 1));
            end
         end
         for (int j = 0; j < NI; j++) begin
            if ($urandom_range(0, 15) == 0) vc_availability[j] = ($urandom_range(0, 7) != 0);
         end
         tick();
         n_cmp++;
         if (vc_read_valid !== m_valid) begin
            n_err++;
            $display("FAIL rand_valid cyc%0d: got %b want %b", c, vc_read_valid, m_valid);
         end
         for (int p = 0; p < NP; p++) begin
            n_cmp++;
            if (vc_index[p] !== VB'(m_idx[p])) begin
               n_err++;
               $display("FAIL rand_index[%0d] cyc%0d: got %0d want %0d", p, c, vc_index[p], m_idx[p]);
            end
         end
      end
   endtask

   initial begin
      reset = 1'b0;
      vc_availability = '1;
      for (int i = 0; i < NI; i++) dst_port[i] = '0;
      model_reset();
      test_reset();
      test_scenario1();
      test_availability();
      test_conflict();
      test_release();
      test_exhaustion();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/router_top.md
Name: router_top

Overview:
- Allocation core of an input-queued virtual-channel (VC) router with NUM_PORTS ports and NUM_VC VCs per port.
- Stage 1, VC allocation: binds each requesting input VC to a free output VC on its requested output port.
- Stage 2, switch allocation: picks at most one VC per input port and one input per output port each cycle, and tells each input buffer which VC to read.
- Sits between the input VC buffers/route computation and the crossbar.

Parameters:
- NUM_PORTS, 5, number of router ports (input = output count).
- NUM_VC, 4, VCs per port.
- PORT_BITS, $clog2(NUM_PORTS), derived.
- VC_BITS, $clog2(NUM_VC), derived.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- dst_port  in  unpacked [NUM_VC*NUM_PORTS] of [NUM_PORTS]  requested output port per input VC, one-hot. Index i = port*NUM_VC + vc. All-zero means no request.
- vc_availability  in  [NUM_VC*NUM_PORTS]  1 = downstream output VC j (j = outport*NUM_VC + vc) has credit/is free.
- vc_index  out  unpacked [NUM_PORTS] of [VC_BITS]  VC that input port p reads this cycle.
- vc_read_valid  out  [NUM_PORTS]  vc_index[p] is valid, meaning input port p won the switch.

Behaviour:
- Internal state allocated_ip_vcs[i], one-hot over NUM_VC*NUM_PORTS: the output VC held by input VC i. Zero means unbound.
- Reset (reset=0, async): all allocated_ip_vcs, round-robin pointers, vc_index and vc_read_valid clear to 0.
- An output VC j is free when vc_availability[j]=1 and no input VC holds j.
- VC allocation, combinational, registered at the clock edge:
  - Every unbound input VC with nonzero dst_port requests all free VCs of that output port.
  - Separable input-first round-robin: each input VC selects one candidate, then each output VC grants at most one input VC.
  - The grant result is vc_grants[i].
  - At the edge, allocated_ip_vcs[i] <= vc_grants[i].
  - Latency: request visible at edge N, binding held after edge N.
- Binding hold/release:
  - A binding is held while dst_port[i] stays nonzero.
  - It is released (cleared) on the first edge where dst_port[i]=0 or dst_port[i] changes.
  - Release and re-allocation cannot occur in the same cycle; the new request is served the next cycle.
- vc_availability going 0 never revokes an existing binding. It only blocks new grants to that VC and blocks switch requests from the VC bound to it.
- Switch allocation uses registered bindings:
  - Input VC i is eligible when allocated_ip_vcs[i]!=0 and vc_availability of its bound output VC is 1.
  - Per input port: round-robin over its eligible VCs (NUM_VC:1).
  - Per output port: round-robin over input ports whose chosen VC targets it (NUM_PORTS:1). The result is allocated_ports[outport], one-hot over input ports.
- Registered outputs at the next edge:
  - Winning input port p: vc_read_valid[p]=1, vc_index[p]=chosen VC.
  - Losing or idle port: vc_read_valid[p]=0 and vc_index[p] holds its previous value.
  - End-to-end latency from request to first vc_read_valid is 2 edges.
- Round-robin pointers update only on a grant, to one past the winner; they wrap from the last index to 0.
- Malformed dst_port (multi-hot): the lowest set bit is used.
- Grants are onto-one: no two input VCs ever hold the same output VC, and no output port is granted to two inputs in one cycle.

Decomposition:
- Package router_pkg: NUM_PORTS/NUM_VC defaults, derived widths, index helper functions (port/vc to flat index).
- Single reusable sub-module rr_arbiter (parameter N; inputs req[N], update; output one-hot gnt[N]; internal pointer).
- rr_arbiter is instantiated for VC input/output arbitration and switch input/output arbitration.

Test Plan:
- Reset: hold reset=0 with active requests -> all bindings 0, vc_read_valid=00000, vc_index all 0.
- Scenario 1 setup: all vc_availability=1; dst_port[0]=00001, dst_port[1]=01000, others 0.
  - After 1 edge: allocated_ip_vcs[0] bit0 set, allocated_ip_vcs[1] bit12 set.
  - After 2 edges: vc_read_valid[0]=1, vc_index[0]=0.
  - Next cycles: vc_index[0] alternates 0/1 (both VCs share input port 0).
- From scenario 1, drive vc_availability[0]=0 -> VC0 binding kept but ineligible; input port 0 serves only VC1 (vc_index[0]=1 every cycle).
- Output conflict: dst_port[0]=00010 and dst_port[4]=00010 (ports 0 and 1 to outport 1), all available -> distinct output VCs 4 and 5 bound; vc_read_valid alternates between ports 0 and 1, never both in one cycle.
- Release: drop dst_port[0] to 0 -> binding cleared next edge, output VC 0 reusable by a new requester on the following cycle.
- Exhaustion: 5 input VCs all request outport 2 -> only 4 bound (VCs 8-11); the fifth binds one cycle after any release.
